// File: rtl/sys_mem_arbiter_pkg.sv
// Shared types and helpers for the system memory arbiter and its sub-blocks.
package sys_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TB    = 2'd2
  } arb_state_t;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int GRANT_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sys_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: per-channel requests in, one-hot ack and shared read data out.
interface sys_mem_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_ren;
  logic [NREQ-1:0]        req_wen;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_store;
  logic [NREQ-1:0]        req_ack;
  logic [DATA_W-1:0]      req_load;

  modport master (
    output req_ren, req_wen, req_addr, req_store,
    input  req_ack, req_load
  );

  modport slave (
    input  req_ren, req_wen, req_addr, req_store,
    output req_ack, req_load
  );
endinterface

// File: rtl/sys_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo NREQ.
module rr_picker
  import sys_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int GW  = GRANT_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    logic [GW:0]   cand;
    logic [GW-1:0] cidx;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    cidx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand  = {1'b0, ptr} + (GW + 1)'(k);
      cand  = (cand >= (GW + 1)'(NREQ)) ? cand - (GW + 1)'(NREQ) : cand;
      cidx  = cand[GW-1:0];
      idx   = req[cidx] ? cidx : idx;
      valid = valid | req[cidx];
    end
  end

endmodule

// File: rtl/sys_mem_arbiter.sv
// Round-robin memory front end: NREQ requesters plus a testbench override onto one RAM port,
// with a grant watchdog and a clock-enable strobe for the cores.
module sys_mem_arbiter
  import sys_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CLKDIV  = 2,
  parameter int TIMEOUT = 64,
  localparam int GW     = GRANT_W(NREQ)
) (
  input  logic              CLK,
  input  logic              nrst,
  sys_mem_arbiter_if.slave  bus,
  input  logic              tb_ctrl,
  input  logic              tb_ren,
  input  logic              tb_wen,
  input  logic [ADDR_W-1:0] tb_addr,
  input  logic [DATA_W-1:0] tb_store,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              cpu_en,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int DIV_W = (CLKDIV <= 1) ? 1 : $clog2(CLKDIV);

  arb_state_t        state;
  logic [GW-1:0]     rr_ptr;
  logic [WD_W-1:0]   wdog;
  logic [DIV_W-1:0]  div_cnt;
  logic [NREQ-1:0]   req_any;
  logic [NREQ-1:0]   ack;
  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     next_ptr;
  logic              g_active;
  logic              div_hit;
  logic [ADDR_W-1:0] ch_addr  [NREQ];
  logic [DATA_W-1:0] ch_store [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ch_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign ch_store[i] = bus.req_store[i*DATA_W +: DATA_W];
  end

  assign req_any  = bus.req_ren | bus.req_wen;
  assign g_active = req_any[grant_id];
  assign next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign div_hit  = (div_cnt == DIV_W'(CLKDIV - 1));
  assign busy     = (state != IDLE);

  // Gated by nrst so that CLKDIV=1 still reads 0 while reset is held.
  assign cpu_en       = nrst & (state != TB) & div_hit;
  assign bus.req_ack  = ack;
  assign bus.req_load = ram_load;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_any),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // RAM port steering and completion ack for the current owner.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    ack       = '0;
    case (state)
      GRANT: begin
        ram_wen       = bus.req_wen[grant_id];
        ram_ren       = bus.req_ren[grant_id] & ~bus.req_wen[grant_id];
        ram_addr      = ch_addr[grant_id];
        ram_store     = ch_store[grant_id];
        ack[grant_id] = ram_ready & g_active;
      end
      TB: begin
        ram_ren   = tb_ren;
        ram_wen   = tb_wen;
        ram_addr  = tb_addr;
        ram_store = tb_store;
      end
      default: begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
      end
    endcase
  end

  // Arbitration FSM with watchdog; an abort leaves rr_ptr alone, completion and timeout advance it.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (tb_ctrl) begin
            state <= TB;
          end else if (pick_valid) begin
            grant_id <= pick_idx;
            state    <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!g_active) begin
            wdog  <= '0;
            state <= IDLE;
          end else if (ram_ready) begin
            rr_ptr <= next_ptr;
            wdog   <= '0;
            state  <= IDLE;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            wdog        <= '0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        TB: begin
          if (!tb_ctrl) begin
            state <= IDLE;
          end else begin
            state <= TB;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Clock-enable divider; frozen while the testbench owns the RAM.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
    end else if (state == TB) begin
      div_cnt <= div_cnt;
    end else if (div_hit) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_sys_mem_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CLKDIV  = 3;
  localparam int TIMEOUT = 8;

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  logic          tb_ctrl, tb_ren, tb_wen, ram_ready;
  logic [AW-1:0] tb_addr, ram_addr;
  logic [DW-1:0] tb_store, ram_store, ram_load;
  logic          ram_ren, ram_wen, cpu_en, busy, timeout_err;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  sys_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sys_mem_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(clk), .nrst(nrst), .bus(bus),
    .tb_ctrl(tb_ctrl), .tb_ren(tb_ren), .tb_wen(tb_wen), .tb_addr(tb_addr), .tb_store(tb_store),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready),
    .cpu_en(cpu_en), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model: owner -1 = nobody, -2 = testbench, 0..NREQ-1 = channel.
  int            m_own, m_ptr, m_wait, m_div, m_gid;
  bit            m_terr;
  logic [NREQ-1:0] e_ack;
  int            ack_log[$];
  int            ready_mode = 3;
  int            tb_left = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_wait = 0; m_div = 0; m_gid = 0; m_terr = 1'b0;
    e_ack = '0;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] rq;
    logic          x_ren, x_wen;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_store;
    rq = bus.req_ren | bus.req_wen;
    e_ack = '0; x_ren = 1'b0; x_wen = 1'b0; x_addr = '0; x_store = '0;
    if (m_own == -2) begin
      x_ren = tb_ren; x_wen = tb_wen; x_addr = tb_addr; x_store = tb_store;
    end else if (m_own >= 0) begin
      x_wen   = bus.req_wen[m_own];
      x_ren   = bus.req_ren[m_own] && !bus.req_wen[m_own];
      x_addr  = bus.req_addr[m_own*AW +: AW];
      x_store = bus.req_store[m_own*DW +: DW];
      if (ram_ready && rq[m_own]) e_ack[m_own] = 1'b1;
    end
    check_eq("busy", busy, m_own != -1);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("timeout_err", timeout_err, m_terr);
    check_eq("cpu_en", cpu_en, nrst && m_own != -2 && m_div == CLKDIV - 1);
    check_eq("ram_ren", ram_ren, x_ren);
    check_eq("ram_wen", ram_wen, x_wen);
    check_eq("ram_addr", ram_addr, x_addr);
    check_eq("ram_store", ram_store, x_store);
    check_eq("req_ack", bus.req_ack, e_ack);
    if (e_ack != '0) check_eq("req_load", bus.req_load, ram_load);
  endtask

  task automatic model_update();
    logic [NREQ-1:0] rq;
    int c;
    if (!nrst) begin
      model_reset();
      return;
    end
    rq = bus.req_ren | bus.req_wen;
    m_terr = 1'b0;
    if (m_own != -2) m_div = (m_div + 1) % CLKDIV;
    if (m_own == -1) begin
      if (tb_ctrl) m_own = -2;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (rq[c] && m_own == -1) begin
            m_own = c; m_gid = c; m_wait = 0;
          end
        end
      end
    end else if (m_own == -2) begin
      if (!tb_ctrl) m_own = -1;
    end else begin
      if (!rq[m_own]) m_own = -1;
      else if (ram_ready) begin
        m_ptr = (m_own + 1) % NREQ; m_own = -1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_terr = 1'b1; m_ptr = (m_own + 1) % NREQ; m_own = -1;
      end else m_wait++;
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk);
  endtask

  task automatic cyc_end();
    #1;
    check_outputs();
    for (int c = 0; c < NREQ; c++) if (bus.req_ack[c]) ack_log.push_back(c);
    @(posedge clk);
    model_update();
  endtask

  task automatic clear_inputs();
    bus.req_ren = '0; bus.req_wen = '0;
    tb_ctrl = 1'b0; tb_ren = 1'b0; tb_wen = 1'b0;
    ram_ready = 1'b0;
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_ren[c] = rd;
    bus.req_wen[c] = wr;
    bus.req_addr[c*AW +: AW] = a;
    bus.req_store[c*DW +: DW] = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(); clear_inputs(); cyc_end();
    end
  endtask

  task automatic gen_random();
    bit       was;
    bit [1:0] v;
    for (int c = 0; c < NREQ; c++) begin
      was = bus.req_ren[c] | bus.req_wen[c];
      if (was && (e_ack[c] || $urandom_range(0, 39) == 0)) begin
        bus.req_ren[c] = 1'b0; bus.req_wen[c] = 1'b0;
      end else if (!was && $urandom_range(0, 2) == 0) begin
        v = 2'($urandom_range(1, 3));
        set_req(c, v[0], v[1], $urandom, $urandom);
      end
    end
    case (ready_mode)
      0:       ram_ready = 1'b0;
      1:       ram_ready = ($urandom_range(0, 3) == 0);
      2:       ram_ready = ($urandom_range(0, 3) != 0);
      default: ram_ready = 1'b1;
    endcase
    ram_load = $urandom;
    if (tb_left > 0) begin
      tb_ctrl = 1'b1; tb_left--;
    end else begin
      tb_ctrl = 1'b0;
      if ($urandom_range(0, 49) == 0) tb_left = $urandom_range(1, 6);
    end
    tb_ren = 1'($urandom); tb_wen = 1'($urandom);
    tb_addr = $urandom; tb_store = $urandom;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      if (i % 40 == 0) ready_mode = $urandom_range(0, 3);
      gen_random();
      cyc_end();
    end
    idle_cycles(3);
  endtask

  initial begin
    int n_to;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    clear_inputs();
    bus.req_addr = '0; bus.req_store = '0;
    tb_addr = '0; tb_store = '0; ram_load = '0;
    model_reset();
    repeat (3) begin cyc_begin(); cyc_end(); end

    // Release with all four requesting and RAM always ready.
    cyc_begin();
    nrst = 1'b1;
    for (int c = 0; c < NREQ; c++) set_req(c, 1'b1, 1'b0, 32'(c * 16), 32'(c));
    ram_ready = 1'b1;
    ack_log.delete();
    cyc_end();
    repeat (9) begin cyc_begin(); cyc_end(); end
    check_eq("rr_ack_count", ack_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) check_eq("rr_order", ack_log[i], exp_order[i]);
    idle_cycles(2);

    // Override requested while ch1 is waiting on the RAM.
    ack_log.delete();
    cyc_begin(); set_req(1, 1'b1, 1'b0, 32'h80, 32'h0); ram_ready = 1'b0; cyc_end();
    cyc_begin(); tb_ctrl = 1'b1; tb_ren = 1'b1; tb_addr = 32'h100; tb_store = 32'h55; cyc_end();
    repeat (2) begin cyc_begin(); cyc_end(); end
    cyc_begin(); ram_ready = 1'b1; cyc_end();
    cyc_begin(); bus.req_ren[1] = 1'b0; ram_ready = 1'b0; cyc_end();
    for (int i = 0; i < 4; i++) begin
      cyc_begin(); #1;
      check_eq("tb_route_addr", ram_addr, 32'h100);
      check_eq("tb_cpu_en_low", cpu_en, 1'b0);
      cyc_end();
    end
    check_eq("tb_first_ack_ch1", (ack_log.size() == 1) ? ack_log[0] : -1, 1);
    idle_cycles(3);

    // Watchdog: ch0 write never completes, ch1 gets the port next.
    ack_log.delete();
    n_to = 0;
    cyc_begin();
    set_req(0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
    set_req(1, 1'b1, 1'b0, 32'h300, 32'h0);
    cyc_end();
    for (int i = 0; i < 11; i++) begin
      cyc_begin();
      ram_ready = (i == 9);
      #1;
      if (timeout_err) n_to++;
      cyc_end();
    end
    check_eq("to_pulses", n_to, 1);
    check_eq("to_next_ch1", (ack_log.size() > 0) ? ack_log[0] : -1, 1);
    idle_cycles(2);

    // Abort by ch2, then a read with ch3 competing to show rr_ptr did not move.
    cyc_begin(); set_req(2, 1'b1, 1'b0, 32'h40, 32'h0); cyc_end();
    cyc_begin(); cyc_end();
    cyc_begin(); bus.req_ren[2] = 1'b0; cyc_end();
    cyc_begin(); cyc_end();
    cyc_begin(); set_req(2, 1'b1, 1'b0, 32'h40, 32'h0); set_req(3, 1'b1, 1'b0, 32'h44, 32'h0); cyc_end();
    cyc_begin();
    ram_ready = 1'b1; ram_load = 32'h1234;
    #1;
    check_eq("abort_read_ack", bus.req_ack, 4'b0100);
    check_eq("abort_read_load", bus.req_load, 32'h1234);
    check_eq("abort_read_addr", ram_addr, 32'h40);
    cyc_end();
    cyc_begin(); bus.req_ren[2] = 1'b0; cyc_end();
    repeat (2) begin cyc_begin(); cyc_end(); end
    idle_cycles(3);

    run_random(2500);

    // Reset during a grant, with rr_ptr left non-zero beforehand.
    cyc_begin(); set_req(2, 1'b1, 1'b0, 32'h10, 32'h0); ram_ready = 1'b1; cyc_end();
    cyc_begin(); cyc_end();
    cyc_begin(); bus.req_ren[2] = 1'b0; ram_ready = 1'b0; cyc_end();
    cyc_begin(); bus.req_ren[2] = 1'b1; cyc_end();
    for (int i = 0; i < 8 && m_own < 0; i++) begin cyc_begin(); cyc_end(); end
    check_eq("pre_reset_in_grant", m_own >= 0, 1'b1);
    cyc_begin();
    #2; nrst = 1'b0; #1;
    check_eq("rst_ram_ren", ram_ren, 1'b0);
    check_eq("rst_ram_wen", ram_wen, 1'b0);
    check_eq("rst_ram_addr", ram_addr, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ack", bus.req_ack, '0);
    check_eq("rst_grant_id", grant_id, '0);
    model_reset();
    cyc_end();
    cyc_begin(); cyc_end();
    ack_log.delete();
    cyc_begin();
    nrst = 1'b1;
    for (int c = 0; c < NREQ; c++) set_req(c, 1'b1, 1'b0, 32'(c), 32'(c));
    ram_ready = 1'b1;
    cyc_end();
    repeat (3) begin cyc_begin(); cyc_end(); end
    check_eq("post_reset_first_ch0", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
    idle_cycles(3);

    run_random(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
